// File: rtl/control.sv
// control: ID-stage decode, branch resolution, operand forwarding and load-use stall
module control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [5:0] func,
  input  logic       rsrtequ,
  input  logic [4:0] exe_regw_addr,
  input  logic [4:0] mem_regw_addr,
  input  logic [4:0] wb_regw_addr,
  input  logic       exe_mem2reg,
  input  logic       exe_wreg,
  input  logic       mem_wreg,
  input  logic       wb_wreg,
  output logic       jal,
  output logic       wreg,
  output logic       branch,
  output logic       mem2reg,
  output logic       wmem,
  output logic [3:0] aluc,
  output logic       aluimm,
  output logic       shift,
  output logic       sext,
  output logic       jr,
  output logic       regrt,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       stall,
  output logic       jump,
  output logic       remain_pc
);
  logic run, r_type, go, hz;
  logic f_add, f_sub, f_and, f_or, f_xor, f_sll, f_srl, f_sra, f_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic r_alu, i_alu, use_rs, use_rt;
  always_ff @(posedge clk) run <= ~rst;
  assign r_type = op == 6'b000000;
  assign f_add  = r_type & (func == 6'b100000);
  assign f_sub  = r_type & (func == 6'b100010);
  assign f_and  = r_type & (func == 6'b100100);
  assign f_or   = r_type & (func == 6'b100101);
  assign f_xor  = r_type & (func == 6'b100110);
  assign f_sll  = r_type & (func == 6'b000000);
  assign f_srl  = r_type & (func == 6'b000010);
  assign f_sra  = r_type & (func == 6'b000011);
  assign f_jr   = r_type & (func == 6'b001000);
  assign i_addi = op == 6'b001000;
  assign i_andi = op == 6'b001100;
  assign i_ori  = op == 6'b001101;
  assign i_xori = op == 6'b001110;
  assign i_lui  = op == 6'b001111;
  assign i_lw   = op == 6'b100011;
  assign i_sw   = op == 6'b101011;
  assign i_beq  = op == 6'b000100;
  assign i_bne  = op == 6'b000101;
  assign i_j    = op == 6'b000010;
  assign i_jal  = op == 6'b000011;
  assign r_alu  = f_add | f_sub | f_and | f_or | f_xor | f_sll | f_srl | f_sra;
  assign i_alu  = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign use_rs = f_add | f_sub | f_and | f_or | f_xor | f_jr | i_addi | i_andi | i_ori | i_xori
                | i_lw | i_sw | i_beq | i_bne;
  assign use_rt = r_alu | f_jr | i_sw | i_beq | i_bne;
  // a load in EXE cannot forward yet, so a consumer must wait one cycle
  assign hz = run & exe_wreg & exe_mem2reg & (exe_regw_addr != 5'd0)
            & ((use_rs & (exe_regw_addr == rs)) | (use_rt & (exe_regw_addr == rt)));
  assign go = run & ~hz;
  function automatic logic [1:0] fwd(input logic [4:0] r);
    return (exe_wreg && exe_regw_addr != 5'd0 && exe_regw_addr == r && !exe_mem2reg) ? 2'b01 :
           (mem_wreg && mem_regw_addr != 5'd0 && mem_regw_addr == r) ? 2'b10 :
           (wb_wreg && wb_regw_addr != 5'd0 && wb_regw_addr == r) ? 2'b11 : 2'b00;
  endfunction
  assign stall     = hz;
  assign remain_pc = hz;
  assign wreg      = go & (r_alu | i_alu | i_lw | i_jal);
  assign wmem      = go & i_sw;
  assign branch    = go & ((i_beq & rsrtequ) | (i_bne & ~rsrtequ));
  assign jump      = go & (i_j | i_jal);
  assign jr        = go & f_jr;
  assign jal       = go & i_jal;
  assign regrt     = run & (i_alu | i_lw);
  assign aluimm    = run & (i_alu | i_lw | i_sw);
  assign sext      = run & (i_addi | i_lw | i_sw | i_beq | i_bne);
  assign shift     = run & (f_sll | f_srl | f_sra);
  assign mem2reg   = run & i_lw;
  assign aluc      = run ? {f_sra,
                            f_sub | f_or | i_ori | f_srl | f_sra | i_lui,
                            f_xor | i_xori | f_sll | f_srl | f_sra | i_lui,
                            f_and | i_andi | f_or | i_ori | f_sll | f_srl | f_sra} : 4'b0000;
  assign fwda      = run ? fwd(rs) : 2'b00;
  assign fwdb      = run ? fwd(rt) : 2'b00;
endmodule

// File: tb/tb_control.sv
// tb_control: scoreboard bench for control with a table-driven instruction reference model
module tb_control;
  typedef struct packed {
    logic jal, wreg, branch, mem2reg, wmem;
    logic [3:0] aluc;
    logic aluimm, shift, sext, jr, regrt;
    logic [1:0] fwda, fwdb;
    logic stall, jump, remain_pc;
  } outs_t;
  typedef enum {I_NOP, I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SRA, I_JR,
                I_ADDI, I_ANDI, I_ORI, I_XORI, I_LUI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL} ins_t;
  logic clk = 0, rst = 1;
  logic [5:0] op, func;
  logic [4:0] rs, rt, exe_regw_addr, mem_regw_addr, wb_regw_addr;
  logic rsrtequ, exe_mem2reg, exe_wreg, mem_wreg, wb_wreg;
  logic jal, wreg, branch, mem2reg, wmem, aluimm, shift, sext, jr, regrt, stall, jump, remain_pc;
  logic [3:0] aluc;
  logic [1:0] fwda, fwdb;
  outs_t act, e;
  outs_t q[$];
  logic mrun = 0;
  int total = 0, bad = 0;
  logic [5:0] op_tab [16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                              6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00, 6'h3f};
  logic [5:0] fn_tab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3f};

  control dut (.clk(clk), .rst(rst), .op(op), .rs(rs), .rt(rt), .func(func), .rsrtequ(rsrtequ),
    .exe_regw_addr(exe_regw_addr), .mem_regw_addr(mem_regw_addr), .wb_regw_addr(wb_regw_addr),
    .exe_mem2reg(exe_mem2reg), .exe_wreg(exe_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
    .jal(jal), .wreg(wreg), .branch(branch), .mem2reg(mem2reg), .wmem(wmem), .aluc(aluc),
    .aluimm(aluimm), .shift(shift), .sext(sext), .jr(jr), .regrt(regrt), .fwda(fwda), .fwdb(fwdb),
    .stall(stall), .jump(jump), .remain_pc(remain_pc));

  assign act = {jal, wreg, branch, mem2reg, wmem, aluc, aluimm, shift, sext, jr, regrt,
                fwda, fwdb, stall, jump, remain_pc};

  always #5 clk = ~clk;

  function automatic ins_t classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: case (f)
        6'h20: return I_ADD;  6'h22: return I_SUB;  6'h24: return I_AND;
        6'h25: return I_OR;   6'h26: return I_XOR;  6'h00: return I_SLL;
        6'h02: return I_SRL;  6'h03: return I_SRA;  6'h08: return I_JR;
        default: return I_NOP;
      endcase
      6'h08: return I_ADDI; 6'h0c: return I_ANDI; 6'h0d: return I_ORI;
      6'h0e: return I_XORI; 6'h0f: return I_LUI;  6'h23: return I_LW;
      6'h2b: return I_SW;   6'h04: return I_BEQ;  6'h05: return I_BNE;
      6'h02: return I_J;    6'h03: return I_JAL;
      default: return I_NOP;
    endcase
  endfunction

  function automatic logic [3:0] aluc_of(input ins_t k);
    case (k)
      I_SUB: return 4'b0100;
      I_AND, I_ANDI: return 4'b0001;
      I_OR, I_ORI: return 4'b0101;
      I_XOR, I_XORI: return 4'b0010;
      I_SLL: return 4'b0011;
      I_SRL: return 4'b0111;
      I_SRA: return 4'b1111;
      I_LUI: return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  // stages listed youngest first; the first writer of a nonzero register wins
  function automatic logic [1:0] fwd_ref(input logic [4:0] r);
    logic w [3];
    logic [4:0] a [3];
    w[0] = exe_wreg && !exe_mem2reg; w[1] = mem_wreg; w[2] = wb_wreg;
    a[0] = exe_regw_addr; a[1] = mem_regw_addr; a[2] = wb_regw_addr;
    for (int s = 0; s < 3; s++) if (w[s] && r != 5'd0 && a[s] == r) return 2'(s + 1);
    return 2'b00;
  endfunction

  function automatic outs_t model();
    outs_t m;
    ins_t k;
    logic urs, urt, hz;
    m = '0;
    if (!mrun) return m;
    k = classify(op, func);
    urs = k inside {I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_JR, I_ADDI, I_ANDI, I_ORI, I_XORI,
                    I_LW, I_SW, I_BEQ, I_BNE};
    urt = k inside {I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SRA, I_JR, I_SW, I_BEQ, I_BNE};
    hz = exe_wreg && exe_mem2reg && exe_regw_addr != 0 &&
         ((urs && exe_regw_addr == rs) || (urt && exe_regw_addr == rt));
    m.aluc    = aluc_of(k);
    m.regrt   = k inside {I_ADDI, I_ANDI, I_ORI, I_XORI, I_LUI, I_LW};
    m.aluimm  = k inside {I_ADDI, I_ANDI, I_ORI, I_XORI, I_LUI, I_LW, I_SW};
    m.sext    = k inside {I_ADDI, I_LW, I_SW, I_BEQ, I_BNE};
    m.shift   = k inside {I_SLL, I_SRL, I_SRA};
    m.mem2reg = k == I_LW;
    m.fwda    = fwd_ref(rs);
    m.fwdb    = fwd_ref(rt);
    m.stall   = hz;
    m.remain_pc = hz;
    if (!hz) begin
      m.wreg   = k inside {I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SRA,
                           I_ADDI, I_ANDI, I_ORI, I_XORI, I_LUI, I_LW, I_JAL};
      m.wmem   = k == I_SW;
      m.branch = (k == I_BEQ && rsrtequ) || (k == I_BNE && !rsrtequ);
      m.jump   = k inside {I_J, I_JAL};
      m.jr     = k == I_JR;
      m.jal    = k == I_JAL;
    end
    return m;
  endfunction

  task automatic cyc();
    @(posedge clk);
    mrun = !rst;
    #1;
  endtask

  task automatic clr();
    op = 0; func = 6'h3f; rs = 0; rt = 0; rsrtequ = 0;
    exe_regw_addr = 0; mem_regw_addr = 0; wb_regw_addr = 0;
    exe_mem2reg = 0; exe_wreg = 0; mem_wreg = 0; wb_wreg = 0;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      outs_t x;
      x = q.pop_front();
      total++;
      if (act !== x) begin
        bad++;
        $display("FAIL outputs t=%0t op=%h func=%h: got %h expected %h", $time, op, func, act, x);
      end
    end
  end

  initial begin
    clr();
    op = 6'h23;
    cyc(); e = '0; q.push_back(e);
    cyc(); e = '0; q.push_back(e);
    cyc(); rst = 0; e = '0; q.push_back(e);
    cyc(); e = '0; e.wreg = 1; e.regrt = 1; e.aluimm = 1; e.sext = 1; e.mem2reg = 1; q.push_back(e);
    cyc(); op = 6'h2b; e = '0; e.wmem = 1; e.aluimm = 1; e.sext = 1; q.push_back(e);
    cyc(); op = 6'h00; func = 6'h00; e = '0; e.wreg = 1; e.shift = 1; e.aluc = 4'b0011; q.push_back(e);
    cyc(); op = 6'h04; rsrtequ = 1; e = '0; e.sext = 1; e.branch = 1; q.push_back(e);
    cyc(); rsrtequ = 0; e = '0; e.sext = 1; q.push_back(e);
    cyc(); op = 6'h05; e = '0; e.sext = 1; e.branch = 1; q.push_back(e);
    cyc(); rsrtequ = 1; e = '0; e.sext = 1; q.push_back(e);
    cyc(); op = 6'h02; e = '0; e.jump = 1; q.push_back(e);
    cyc(); op = 6'h03; e = '0; e.jump = 1; e.jal = 1; e.wreg = 1; q.push_back(e);
    cyc(); clr(); func = 6'h20; rs = 5; rt = 6; exe_wreg = 1; exe_regw_addr = 5;
    e = '0; e.wreg = 1; e.fwda = 2'b01; q.push_back(e);
    cyc(); mem_wreg = 1; mem_regw_addr = 6; e = '0; e.wreg = 1; e.fwda = 2'b01; e.fwdb = 2'b10; q.push_back(e);
    cyc(); wb_wreg = 1; wb_regw_addr = 6; e = '0; e.wreg = 1; e.fwda = 2'b01; e.fwdb = 2'b10; q.push_back(e);
    cyc(); mem_regw_addr = 0; e = '0; e.wreg = 1; e.fwda = 2'b01; e.fwdb = 2'b11; q.push_back(e);
    cyc(); rs = 0; rt = 0; exe_regw_addr = 0; wb_regw_addr = 0; e = '0; e.wreg = 1; q.push_back(e);
    cyc(); clr(); func = 6'h20; rs = 5; rt = 6; exe_wreg = 1; exe_mem2reg = 1; exe_regw_addr = 5;
    e = '0; e.stall = 1; e.remain_pc = 1; q.push_back(e);
    cyc(); op = 6'h0f; e = '0; e.wreg = 1; e.regrt = 1; e.aluimm = 1; e.aluc = 4'b0110; q.push_back(e);
    cyc(); clr(); func = 6'h20; rs = 1; rt = 2; rst = 1; e = '0; e.wreg = 1; q.push_back(e);
    cyc(); rst = 0; e = '0; q.push_back(e);
    cyc(); e = '0; e.wreg = 1; q.push_back(e);
    for (int n = 0; n < 600; n++) begin
      cyc();
      rst = $urandom_range(0, 39) == 0;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 15)];
      func = fn_tab[$urandom_range(0, 9)];
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      rsrtequ = 1'($urandom);
      exe_regw_addr = 5'($urandom_range(0, 3));
      mem_regw_addr = 5'($urandom_range(0, 3));
      wb_regw_addr = 5'($urandom_range(0, 3));
      exe_wreg = 1'($urandom); mem_wreg = 1'($urandom); wb_wreg = 1'($urandom);
      exe_mem2reg = $urandom_range(0, 2) == 0;
      q.push_back(model());
    end
    cyc();
    cyc();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control.md
Name: control

Overview:
- Instruction-decode-stage control unit for the team's 5-stage MIPS pipeline (IF/ID/EXE/MEM/WB).
- Decodes op/func into datapath control signals.
- Resolves branches in ID using the rsrtequ comparator input.
- Produces the operand forwarding selects and the load-use stall / PC-hold signals.
- Decode is combinational; one internal start-up register gives a synchronous reset.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  6  instruction[31:26].
- rs  input  5  instruction[25:21].
- rt  input  5  instruction[20:16].
- func  input  6  instruction[5:0].
- rsrtequ  input  1  forwarded rs value == forwarded rt value.
- exe_regw_addr  input  5  destination register of the instruction in EXE.
- mem_regw_addr  input  5  destination register in MEM.
- wb_regw_addr  input  5  destination register in WB.
- exe_mem2reg  input  1  EXE instruction is a load.
- exe_wreg  input  1  EXE instruction writes the register file.
- mem_wreg  input  1  MEM instruction writes the register file.
- wb_wreg  input  1  WB instruction writes the register file.
- jal  output  1  jal: write PC+8 to r31.
- wreg  output  1  register-file write enable.
- branch  output  1  taken conditional branch.
- mem2reg  output  1  writeback from memory.
- wmem  output  1  data memory write.
- aluc  output  4  ALU operation.
- aluimm  output  1  ALU B operand is the immediate.
- shift  output  1  ALU A operand is shamt.
- sext  output  1  sign-extend the immediate (0 = zero-extend).
- jr  output  1  jump register.
- regrt  output  1  destination is rt (0 = rd).
- fwda  output  2  rs operand source.
- fwdb  output  2  rt operand source.
- stall  output  1  load-use hazard; insert bubble.
- jump  output  1  j/jal taken.
- remain_pc  output  1  hold PC and IF/ID register.

Behaviour:
- Reset and start-up register:
  - Internal flag "run" is cleared at a clk edge while rst=1 and set at the first clk edge with rst=0.
  - While run=0, every output is 0; fwda = fwdb = 00.
  - Reset asserted mid-operation takes effect at the next clk edge.
  - Everything below is combinational from the inputs, qualified by run=1.
- Supported instructions (op/func), with aluc:
  - R-type (op=000000): add 100000 aluc 0000; sub 100010 aluc 0100; and 100100 aluc 0001; or 100101 aluc 0101; xor 100110 aluc 0010; sll 000000 aluc 0011; srl 000010 aluc 0111; sra 000011 aluc 1111; jr 001000.
  - I-type ALU: addi 001000 aluc 0000; andi 001100 aluc 0001; ori 001101 aluc 0101; xori 001110 aluc 0010; lui 001111 aluc 0110.
  - Memory and branches: lw 100011 and sw 101011 (aluc 0000); beq 000100; bne 000101.
  - Jumps: j 000010; jal 000011.
  - aluc is 0000 for every instruction not listed above with an aluc value.
- Control signal assignments:
  - wreg: R-type ALU ops, I-type ALU ops, lw, jal.
  - regrt: I-type ALU ops and lw.
  - aluimm: I-type ALU ops, lw, sw.
  - sext: addi, lw, sw, beq, bne.
  - shift: sll, srl, sra.
  - mem2reg: lw. wmem: sw. jal: jal.
  - jump: j or jal. jr: jr.
  - branch = (beq & rsrtequ) | (bne & ~rsrtequ).
- Unknown op or R-type func: all control outputs 0 (treated as a nop); forwarding logic still evaluated.
- Register usage:
  - Uses rs: R-type except sll/srl/sra; addi, andi, ori, xori, lw, sw, beq, bne; jr.
  - Uses rt: all R-type, sw, beq, bne.
- Forwarding (fwda for rs, fwdb for rt, same rule on each operand), first match wins:
  - 01 (EXE ALU result) if exe_wreg & exe_regw_addr!=0 & exe_regw_addr==reg & ~exe_mem2reg.
  - 10 (MEM result) if mem_wreg & mem_regw_addr!=0 & mem_regw_addr==reg.
  - 11 (WB result) if wb_wreg & wb_regw_addr!=0 & wb_regw_addr==reg.
  - 00 (register file) otherwise.
  - Register 0 is never forwarded.
- Stall:
  - stall = exe_wreg & exe_mem2reg & exe_regw_addr!=0 & ((uses rs & exe_regw_addr==rs) | (uses rt & exe_regw_addr==rt)).
  - remain_pc = stall.
  - While stall=1: wreg, wmem, branch, jump, jr and jal are forced 0 (bubble into EXE, no redirect).
  - Other outputs keep their decoded values while stalled.

Test Plan:
- Hold rst=1 for 2 clocks, op=100011 -> all outputs 0. Release rst; after 1 clk, lw -> wreg=1, regrt=1, aluimm=1, sext=1, mem2reg=1, aluc=0000, wmem=0.
- op=101011 (sw) -> wmem=1, wreg=0, aluimm=1, sext=1. op=000000, func=000000 (sll) -> wreg=1, shift=1, regrt=0, aluc=0011.
- beq, rsrtequ=1 -> branch=1; rsrtequ=0 -> branch=0. bne gives the inverse. j -> jump=1. jal -> jump=1, jal=1, wreg=1.
- add, rs=5, rt=6: exe_wreg=1, exe_regw_addr=5 -> fwda=01. Then mem_wreg=1, mem_regw_addr=6 -> fwdb=10. Then wb_wreg=1, wb_regw_addr=6 with MEM also matching -> fwdb=10 (MEM priority). Any address=0 -> 00.
- add, rs=5; exe_wreg=1, exe_mem2reg=1, exe_regw_addr=5 -> stall=1, remain_pc=1, wreg=0. Same hazard with lui (rs unused) -> stall=0.
- Pulse rst=1 for one clock mid-stream with a valid add -> outputs 0 for that cycle, decoding resumes the following cycle.
